// File: rtl/voltage_to_code_if.sv
// Request/result handshake bundle for voltage_to_code.
// master drives the digits and out_ready; slave is the converter.
interface voltage_to_code_if #(
   parameter int unsigned ADC_BITS = 12
) ();
   logic                in_valid;
   logic                in_ready;
   logic [7:0]          int_digit;
   logic [7:0]          frac1_digit;
   logic [7:0]          frac2_digit;
   logic                out_valid;
   logic                out_ready;
   logic [ADC_BITS-1:0] out_code;
   logic                out_sat;
   logic                out_err;

   modport master (
      output in_valid, int_digit, frac1_digit, frac2_digit, out_ready,
      input  in_ready, out_valid, out_code, out_sat, out_err
   );

   modport slave (
      input  in_valid, int_digit, frac1_digit, frac2_digit, out_ready,
      output in_ready, out_valid, out_code, out_sat, out_err
   );
endinterface

// File: rtl/voltage_to_code.sv
// Converts a decimal voltage (d.dd volts) to the equivalent ADC code via a bit-serial restoring divide.
// Optional macro VOLTAGE_TO_CODE_ROUND_EN selects round-to-nearest instead of truncation.
module voltage_to_code #(
   parameter int unsigned VREF_MV  = 5000,
   parameter int unsigned ADC_BITS = 12,
   parameter int unsigned DIV_W    = 26
) (
   input logic               clk,
   input logic               rst,
   voltage_to_code_if.slave  bus
);
   localparam int unsigned MV_W  = 14;
   localparam int unsigned DIG_W = 8;
   localparam int unsigned CNT_W = $clog2(DIV_W);

`ifdef VOLTAGE_TO_CODE_ROUND_EN
   localparam logic [DIV_W-1:0] ROUND_ADD = DIV_W'(VREF_MV / 2);
`else
   localparam logic [DIV_W-1:0] ROUND_ADD = '0;
`endif

   typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;

   state_t              state;
   logic [DIG_W-1:0]    d_int, d_f1, d_f2;
   logic [DIV_W-1:0]    num;
   logic [DIV_W-1:0]    rem;
   logic [ADC_BITS-1:0] quo;
   logic [CNT_W-1:0]    cnt;
   logic                in_ready_q;
   logic                out_valid_q;
   logic [ADC_BITS-1:0] out_code_q;
   logic                out_sat_q;
   logic                out_err_q;

   logic                digit_err_c;
   logic [MV_W-1:0]     mv_c;
   logic [DIV_W:0]      rem_shift_c;
   logic                rem_ge_c;

   // Digit check, millivolt value and one restoring-divide step
   always_comb begin
      digit_err_c = (d_int > DIG_W'(9)) || (d_f1 > DIG_W'(9)) || (d_f2 > DIG_W'(9));
      mv_c        = MV_W'(d_int[3:0]) * MV_W'(1000)
                  + MV_W'(d_f1[3:0])  * MV_W'(100)
                  + MV_W'(d_f2[3:0])  * MV_W'(10);
      rem_shift_c = {rem, num[DIV_W-1]};
      rem_ge_c    = (rem_shift_c >= (DIV_W+1)'(VREF_MV));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         d_int       <= '0;
         d_f1        <= '0;
         d_f2        <= '0;
         num         <= '0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_sat_q   <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  d_int      <= bus.int_digit;
                  d_f1       <= bus.frac1_digit;
                  d_f2       <= bus.frac2_digit;
                  in_ready_q <= 1'b0;
                  state      <= CALC;
               end
            end
            CALC: begin
               // Bad digits take precedence over the saturation clamp
               if (digit_err_c) begin
                  out_err_q  <= 1'b1;
                  out_sat_q  <= 1'b0;
                  out_code_q <= '0;
                  state      <= DONE;
               end else if (mv_c >= MV_W'(VREF_MV)) begin
                  out_err_q  <= 1'b0;
                  out_sat_q  <= 1'b1;
                  out_code_q <= '1;
                  state      <= DONE;
               end else begin
                  out_err_q  <= 1'b0;
                  out_sat_q  <= 1'b0;
                  num        <= (DIV_W'(mv_c) << ADC_BITS) + ROUND_ADD;
                  rem        <= '0;
                  quo        <= '0;
                  cnt        <= CNT_W'(DIV_W - 1);
                  state      <= DIV;
               end
            end
            DIV: begin
               num <= {num[DIV_W-2:0], 1'b0};
               rem <= rem_ge_c ? DIV_W'(rem_shift_c - (DIV_W+1)'(VREF_MV))
                               : rem_shift_c[DIV_W-1:0];
               // Quotient upper bits are always zero since mv < VREF_MV
               quo <= {quo[ADC_BITS-2:0], rem_ge_c};
               if (cnt == CNT_W'(0)) begin
                  out_code_q <= {quo[ADC_BITS-2:0], rem_ge_c};
                  state      <= DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_code  = out_code_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_voltage_to_code.sv
// Directed bench for voltage_to_code: vector table plus backpressure and mid-divide reset sequences.
module tb_voltage_to_code;
   localparam int unsigned ADC_BITS = 12;

`ifdef VOLTAGE_TO_CODE_ROUND_EN
   localparam int C123 = 1008;
   localparam int C499 = 4088;
`else
   localparam int C123 = 1007;
   localparam int C499 = 4087;
`endif

   typedef struct {
      int d0, d1, d2;
      int code, sat, err, lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_mis = 0;
   vec_t vecs[10];

   always #5 clk = ~clk;

   voltage_to_code_if #(.ADC_BITS(ADC_BITS)) bus ();

   voltage_to_code #(.VREF_MV(5000), .ADC_BITS(ADC_BITS), .DIV_W(26)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic request(input int a, input int b, input int c);
      int w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_before_req", int'(bus.in_ready), 1);
      bus.in_valid    = 1'b1;
      bus.int_digit   = 8'(a);
      bus.frac1_digit = 8'(b);
      bus.frac2_digit = 8'(c);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.out_valid && lat < 100);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      request(v.d0, v.d1, v.d2);
      wait_valid(lat);
      check($sformatf("latency_%0d%0d%0d", v.d0, v.d1, v.d2), lat, v.lat);
      check($sformatf("code_%0d%0d%0d", v.d0, v.d1, v.d2), int'(bus.out_code), v.code);
      check($sformatf("sat_%0d%0d%0d", v.d0, v.d1, v.d2), int'(bus.out_sat), v.sat);
      check($sformatf("err_%0d%0d%0d", v.d0, v.d1, v.d2), int'(bus.out_err), v.err);
      @(posedge clk);
      #1;
      check("out_valid_after_accept", int'(bus.out_valid), 0);
      check("in_ready_after_accept", int'(bus.in_ready), 1);
   endtask

   initial begin
      int   lat;
      int   held_code;
      logic seen_valid;
      vec_t v;

      vecs[0] = '{2, 5, 0, 2048, 0, 0, 28};
      vecs[1] = '{1, 2, 3, C123, 0, 0, 28};
      vecs[2] = '{4, 9, 9, C499, 0, 0, 28};
      vecs[3] = '{0, 0, 0, 0,    0, 0, 28};
      vecs[4] = '{5, 0, 0, 4095, 1, 0, 2};
      vecs[5] = '{9, 9, 9, 4095, 1, 0, 2};
      vecs[6] = '{3, 10, 0, 0,   0, 1, 2};
      vecs[7] = '{12, 0, 0, 0,   0, 1, 2};
      vecs[8] = '{3, 3, 0, 2703, 0, 0, 28};
      vecs[9] = '{1, 0, 0, 819,  0, 0, 28};

      bus.in_valid    = 1'b0;
      bus.int_digit   = 8'd0;
      bus.frac1_digit = 8'd0;
      bus.frac2_digit = 8'd0;
      bus.out_ready   = 1'b1;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_code", int'(bus.out_code), 0);
      check("rst_out_sat", int'(bus.out_sat), 0);
      check("rst_out_err", int'(bus.out_err), 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Backpressure: result held, in_ready low, new requests ignored
      bus.out_ready = 1'b0;
      request(4, 9, 9);
      wait_valid(lat);
      check("bp_latency", lat, 28);
      held_code = C499;
      bus.in_valid    = 1'b1;
      bus.int_digit   = 8'd0;
      bus.frac1_digit = 8'd0;
      bus.frac2_digit = 8'd0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid_held", int'(bus.out_valid), 1);
         check("bp_out_code_held", int'(bus.out_code), held_code);
         check("bp_in_ready_low", int'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", int'(bus.out_valid), 0);
      check("bp_release_in_ready", int'(bus.in_ready), 1);
      v = '{3, 3, 0, 2703, 0, 0, 28};
      run_vec(v);

      // Reset mid-divide aborts the conversion
      request(2, 5, 0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_in_ready", int'(bus.in_ready), 1);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_out_code", int'(bus.out_code), 0);
      check("midrst_out_sat", int'(bus.out_sat), 0);
      check("midrst_out_err", int'(bus.out_err), 0);
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen_valid = 1'b1;
      end
      check("midrst_no_out_valid", int'(seen_valid), 0);
      v = '{1, 0, 0, 819, 0, 0, 28};
      run_vec(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
